// File: rtl/logic_gates_bist.sv
// Built-in self-test sequencer for a two-input gate bank: walks {a,b} through
// 00..11, compares the eight gate outputs after a settle time and reports results.
module logic_gates_bist #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       not1_in,
    input  logic       not2_in,
    input  logic       and1_in,
    input  logic       or1_in,
    input  logic       nand1_in,
    input  logic       nor1_in,
    input  logic       xor1_in,
    input  logic       xnor1_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_mask,
    output logic [2:0] err_vec_count,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_valid,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] fail_mask_q, fail_mask_d;
    logic [2:0] err_cnt_q, err_cnt_d;
    logic [1:0] ffv_q, ffv_d;
    logic       ffvalid_q, ffvalid_d;
    logic       pass_q, pass_d;

    logic       vec_a, vec_b;
    logic [7:0] sampled, expected, mism;

    assign vec_a    = idx_q[1];
    assign vec_b    = idx_q[0];
    // Bit order matches fail_mask: not1, not2, and1, or1, nand1, nor1, xor1, xnor1.
    assign sampled  = {xnor1_in, xor1_in, nor1_in, nand1_in, or1_in, and1_in, not2_in, not1_in};
    assign expected = {~(vec_a ^ vec_b), vec_a ^ vec_b, ~(vec_a | vec_b), ~(vec_a & vec_b),
                       vec_a | vec_b, vec_a & vec_b, ~vec_b, ~vec_a};
    assign mism     = sampled ^ expected;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= 8'd0;
            fail_mask_q <= 8'd0;
            err_cnt_q   <= 3'd0;
            ffv_q       <= 2'd0;
            ffvalid_q   <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            fail_mask_q <= fail_mask_d;
            err_cnt_q   <= err_cnt_d;
            ffv_q       <= ffv_d;
            ffvalid_q   <= ffvalid_d;
            pass_q      <= pass_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        fail_mask_d = fail_mask_q;
        err_cnt_d   = err_cnt_q;
        ffv_d       = ffv_q;
        ffvalid_d   = ffvalid_q;
        pass_d      = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WAIT;
                    idx_d       = 2'd0;
                    cnt_d       = RELOAD;
                    fail_mask_d = 8'd0;
                    err_cnt_d   = 3'd0;
                    ffv_d       = 2'd0;
                    ffvalid_d   = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_CMP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_CMP: begin
                fail_mask_d = fail_mask_q | mism;
                if (|mism) begin
                    err_cnt_d = err_cnt_q + 3'd1;
                    if (!ffvalid_q) begin
                        ffv_d     = idx_q;
                        ffvalid_d = 1'b1;
                    end
                end
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                    // pass must include the mismatches of this final compare.
                    pass_d  = ((fail_mask_q | mism) == 8'd0);
                end else begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = RELOAD;
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy             = (state_q == S_WAIT) || (state_q == S_CMP);
    assign done             = (state_q == S_DONE);
    assign a_out            = busy & vec_a;
    assign b_out            = busy & vec_b;
    assign pass             = pass_q;
    assign fail_mask        = fail_mask_q;
    assign err_vec_count    = err_cnt_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_logic_gates_bist.sv
// Self-checking bench: cycle-level model of a BIST run derived from the run
// timeline (cycle index within the run), plus directed scenarios with literal pins.
module tb_logic_gates_bist;

    localparam int S = 2;
    localparam int L = 4 * (S + 1);

    logic clk = 1'b0;
    logic rst, start, start1;
    int   mode;
    always #5 clk = ~clk;

    // DUT with SETTLE_CYCLES=2 and a bank whose fault is selected by mode
    logic       a_out, b_out, busy, done, pass, ffvalid;
    logic [7:0] bank_o, fail_mask;
    logic [2:0] err_cnt;
    logic [1:0] ffv, dbg_state;

    // second DUT with SETTLE_CYCLES=1 and a golden bank
    logic       a1, b1, busy1, done1, pass1, ffvalid1;
    logic [7:0] bank1_o, fail_mask1;
    logic [2:0] err_cnt1;
    logic [1:0] ffv1, dbg_state1;

    // Bank outputs in fail_mask bit order; mode 1 ties and1 low, mode 2 swaps xor/xnor.
    function automatic logic [7:0] ideal(input logic a, input logic b);
        logic [7:0] r;
        r[0] = !a;      r[1] = !b;
        r[2] = a && b;  r[3] = a || b;
        r[4] = !(a && b); r[5] = !(a || b);
        r[6] = a != b;  r[7] = a == b;
        return r;
    endfunction

    function automatic logic [7:0] bank(input int m, input logic a, input logic b);
        logic [7:0] r;
        r = ideal(a, b);
        if (m == 1) r[2] = 1'b0;
        if (m == 2) r = {r[6], r[7], r[5:0]};
        return r;
    endfunction

    assign bank_o  = bank(mode, a_out, b_out);
    assign bank1_o = bank(0, a1, b1);

    logic_gates_bist #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out),
        .not1_in(bank_o[0]), .not2_in(bank_o[1]), .and1_in(bank_o[2]), .or1_in(bank_o[3]),
        .nand1_in(bank_o[4]), .nor1_in(bank_o[5]), .xor1_in(bank_o[6]), .xnor1_in(bank_o[7]),
        .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
        .err_vec_count(err_cnt), .first_fail_vec(ffv), .first_fail_valid(ffvalid),
        .dbg_state(dbg_state)
    );

    logic_gates_bist #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1),
        .not1_in(bank1_o[0]), .not2_in(bank1_o[1]), .and1_in(bank1_o[2]), .or1_in(bank1_o[3]),
        .nand1_in(bank1_o[4]), .nor1_in(bank1_o[5]), .xor1_in(bank1_o[6]), .xnor1_in(bank1_o[7]),
        .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fail_mask1),
        .err_vec_count(err_cnt1), .first_fail_vec(ffv1), .first_fail_valid(ffvalid1),
        .dbg_state(dbg_state1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: m_t is the cycle number within a run (0 idle, 1..L busy, L+1 done).
    int         m_t = 0;
    logic [7:0] m_mask = '0;
    int         m_err = 0;
    logic [1:0] m_ffv = '0;
    logic       m_ffval = 1'b0;
    logic       m_pass = 1'b0;
    logic       chk_en = 1'b0;

    always @(posedge clk) begin
        int v;
        logic [7:0] d;
        if (rst) begin
            m_t = 0; m_mask = '0; m_err = 0; m_ffv = '0; m_ffval = 1'b0; m_pass = 1'b0;
            chk_en = 1'b1;
        end else if (m_t == 0) begin
            if (start) begin
                m_t = 1; m_mask = '0; m_err = 0; m_ffv = '0; m_ffval = 1'b0; m_pass = 1'b0;
            end
        end else if (m_t <= L) begin
            if ((m_t - 1) % (S + 1) == S) begin
                v = (m_t - 1) / (S + 1);
                d = bank(mode, v[1], v[0]) ^ ideal(v[1], v[0]);
                if (d != 0) begin
                    m_mask |= d;
                    m_err++;
                    if (!m_ffval) begin
                        m_ffv = v[1:0];
                        m_ffval = 1'b1;
                    end
                end
            end
            if (m_t == L) m_pass = (m_mask == 0);
            m_t++;
        end else begin
            m_t = 0;
        end
    end

    always @(negedge clk) begin
        int v;
        logic mb;
        if (chk_en) begin
            mb = (m_t >= 1) && (m_t <= L);
            v  = mb ? (m_t - 1) / (S + 1) : 0;
            chk("busy", 32'(busy), 32'(mb));
            chk("done", 32'(done), 32'(m_t == L + 1));
            chk("a_out", 32'(a_out), 32'(v[1]));
            chk("b_out", 32'(b_out), 32'(v[0]));
            chk("pass", 32'(pass), 32'(m_pass));
            chk("fail_mask", 32'(fail_mask), 32'(m_mask));
            chk("err_vec_count", 32'(err_cnt), 32'(m_err));
            chk("first_fail_vec", 32'(ffv), 32'(m_ffv));
            chk("first_fail_valid", 32'(ffvalid), 32'(m_ffval));
        end
    end

    // Pulses start then returns the run cycle in which done is seen (0 on timeout).
    task automatic do_run(input int pulse_at, output int done_cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            start = (c == pulse_at);
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_terminates", 32'(done_cyc != 0), 32'd1);
        @(negedge clk);
    endtask

    int dc;
    logic [1:0] exp_ab;

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mask", 32'(fail_mask), 32'd0);
        chk("reset_ab", 32'({a_out, b_out}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // golden bank, with a start pulse in cycle 6 that must be ignored
        mode = 0;
        do_run(6, dc);
        chk("golden_done_cycle", 32'(dc), 32'd13);
        chk("golden_pass", 32'(pass), 32'd1);
        chk("golden_mask", 32'(fail_mask), 32'h00);
        chk("golden_err", 32'(err_cnt), 32'd0);
        chk("golden_ffvalid", 32'(ffvalid), 32'd0);
        chk("golden_idle_after", 32'(busy), 32'd0);

        // and1 stuck at 0
        mode = 1;
        do_run(0, dc);
        chk("and1_done_cycle", 32'(dc), 32'd13);
        chk("and1_mask", 32'(fail_mask), 32'h04);
        chk("and1_err", 32'(err_cnt), 32'd1);
        chk("and1_ffv", 32'(ffv), 32'b11);
        chk("and1_ffvalid", 32'(ffvalid), 32'd1);
        chk("and1_pass", 32'(pass), 32'd0);

        // xor/xnor swapped
        mode = 2;
        do_run(0, dc);
        chk("swap_mask", 32'(fail_mask), 32'hC0);
        chk("swap_err", 32'(err_cnt), 32'd4);
        chk("swap_ffv", 32'(ffv), 32'b00);
        chk("swap_ffvalid", 32'(ffvalid), 32'd1);
        chk("swap_pass", 32'(pass), 32'd0);

        // start held high, golden bank: back-to-back runs
        mode = 0;
        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 27; c++) begin
            if (c == 2) chk("held_cleared_mask", 32'(fail_mask), 32'h00);
            if (c == 13) chk("held_done1", 32'(done), 32'd1);
            if (c == 14) chk("held_idle", 32'(busy), 32'd0);
            if (c == 15) chk("held_rebusy", 32'(busy), 32'd1);
            if (c == 27) begin
                chk("held_done2", 32'(done), 32'd1);
                chk("held_pass2", 32'(pass), 32'd1);
                start = 1'b0;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // reset at the edge ending cycle 5 of a failing run
        mode = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 5; c++) @(negedge clk);
        chk("pre_reset_mask", 32'(fail_mask), 32'hC0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ab", 32'({a_out, b_out}), 32'd0);
        chk("rst_mask", 32'(fail_mask), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_ffvalid", 32'(ffvalid), 32'd0);
        for (int c = 0; c < 15; c++) begin
            chk("rst_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        mode = 0;
        do_run(0, dc);
        chk("post_rst_done_cycle", 32'(dc), 32'd13);
        chk("post_rst_pass", 32'(pass), 32'd1);

        // SETTLE_CYCLES=1 instance: each vector driven for two cycles
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) begin
                exp_ab = 2'((c - 1) / 2);
                chk("s1_ab", 32'({a1, b1}), 32'(exp_ab));
                chk("s1_busy", 32'(busy1), 32'd1);
            end else begin
                chk("s1_done", 32'(done1), 32'd1);
                chk("s1_pass", 32'(pass1), 32'd1);
                chk("s1_ab_idle", 32'({a1, b1}), 32'd0);
            end
            @(negedge clk);
        end
        chk("s1_done_once", 32'(done1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logic_gates_bist.md
Name: logic_gates_bist

Overview:
- Self-test sequencer that sits on the opposite side of the two-input gate bank interface.
- Drives the gate-bank inputs `a`/`b` through all four input combinations.
- Samples the eight gate outputs (not1, not2, and1, or1, nand1, nor1, xor1, xnor1) after a settle time and compares them against internally computed expected values.
- Reports pass/fail, a per-output failure mask and the first failing vector. Used as power-up/bench BIST for the gate bank.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before its compare cycle; legal range 1..255 (8-bit wait counter).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a test run; accepted only in IDLE
- a_out  output  1  drive to gate bank input a
- b_out  output  1  drive to gate bank input b
- not1_in, not2_in, and1_in, or1_in, nand1_in, nor1_in, xor1_in, xnor1_in  input  1 each  gate bank outputs
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at end of run
- pass  output  1  last run had no mismatches; held until next start
- fail_mask  output  8  sticky per-output mismatch flags
  - bit0 not1, bit1 not2, bit2 and1, bit3 or1, bit4 nand1, bit5 nor1, bit6 xor1, bit7 xnor1
- err_vec_count  output  3  number of vectors (0..4) with any mismatch
- first_fail_vec  output  2  {a,b} of first failing vector
- first_fail_valid  output  1  first_fail_vec is meaningful

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE. All outputs 0: a_out, b_out, busy, done, pass, fail_mask, err_vec_count, first_fail_vec, first_fail_valid. Wait counter and vector index are cleared.
- Reset mid-run aborts immediately; no done pulse is produced.
- States:
  - IDLE: a_out=b_out=0. start=1 → WAIT; vector index=0, wait counter=SETTLE_CYCLES-1. fail_mask, err_vec_count, first_fail_vec, first_fail_valid and pass are cleared on the same edge.
  - WAIT: a_out/b_out = vector index {a,b}. Counter decrements each cycle; at 0 → CMP.
  - CMP: the same vector is still driven. Expected values are computed from the current vector: ~a, ~b, a&b, a|b, ~(a&b), ~(a|b), a^b, ~(a^b).
    - At the edge ending CMP: fail_mask |= (sampled XOR expected). If any bit mismatches, err_vec_count increments.
    - If any bit mismatches and first_fail_valid=0: capture first_fail_vec=index and set first_fail_valid=1.
    - If index<3: index+1, counter reloads, → WAIT. If index=3: → DONE.
  - DONE: busy=0, done=1 for exactly one cycle. pass=1 iff fail_mask==0, registered on entry to DONE and held. a_out/b_out return to 0. Unconditionally → IDLE.
- busy=1 in WAIT and CMP only.
- Vector order is fixed: 00, 01, 10, 11 ({a_out,b_out}).
- Timing: cycle 1 is the first cycle after the edge that samples start.
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - busy is high in cycles 1..4*(SETTLE_CYCLES+1); done is high in cycle 4*(SETTLE_CYCLES+1)+1.
- start while busy or in DONE is ignored, with no effect on the run.
- If start is held continuously, a new run is accepted in the IDLE cycle following DONE.
- Gate inputs are sampled only at the CMP edge; glitches during WAIT are ignored.
- err_vec_count saturates naturally at 4, so no overflow is possible.
- Result outputs are stable from DONE until the next accepted start or reset.

Test Plan:
- Golden gate bank attached, SETTLE_CYCLES=2, pulse start → busy cycles 1..12, done in cycle 13, pass=1, fail_mask=8'h00, err_vec_count=0, first_fail_valid=0.
- and1_in tied to 0 → mismatch only on vector 11: fail_mask=8'h04, err_vec_count=1, first_fail_vec=2'b11, first_fail_valid=1, pass=0.
- xor1_in/xnor1_in swapped → every vector fails: fail_mask=8'hC0, err_vec_count=4, first_fail_vec=2'b00, pass=0.
- start held high with golden bank → done in cycle 13, IDLE in cycle 14, busy again from cycle 15; results clear at the second start and end with pass=1 again. A start pulse in cycle 6 of a run has no effect.
- rst asserted at the cycle 5 edge mid-run → next cycle busy=0, a_out=b_out=0, all result outputs 0, no done. A following start completes a normal run.
- SETTLE_CYCLES=1 → each vector is driven for 2 cycles (a_out/b_out sequence 00,00,01,01,10,10,11,11), done in cycle 9.
